// File: rtl/jtag_dmi_master.sv
// JTAG master that bit-bangs RISC-V DMI accesses: selects DMIACCESS once after
// reset, then runs a request scan and a result scan for every accepted request.
module jtag_dmi_master #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned IDLE_TCKS = 8,
  parameter logic [4:0]  DMI_IR    = 5'h11,
  parameter int unsigned MAX_RETRY = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [6:0]  req_addr_i,
  input  logic [31:0] req_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [1:0]  rsp_op_o,
  output logic        tck_o,
  output logic        tms_o,
  output logic        tdi_o,
  output logic        trst_no,
  input  logic        tdo_i
);

  typedef enum logic [3:0] {
    TRST, TAP_RESET, IDLE, SEL_IR, SHIFT_IR, SEL_DR, SHIFT_DR, UPDATE, RTI_WAIT, RESP
  } state_t;

  localparam logic [7:0]  DIV_LAST    = 8'(CLK_DIV - 1);
  localparam logic [15:0] IDLE_LAST   = 16'(IDLE_TCKS - 1);
  localparam logic [4:0]  RETRY_LIMIT = 5'(MAX_RETRY);

  state_t       state, state_next;
  logic [15:0]  step, step_next;
  logic [40:0]  sr, sr_next;
  logic         scan_b, scan_b_next;
  logic [4:0]   retry, retry_next;
  logic [31:0]  rsp_data_next;
  logic [1:0]   rsp_op_next;
  logic [7:0]   div_cnt;
  logic         tck_q, tdo_q;
  logic [1:0]   op_q;
  logic [6:0]   addr_q;
  logic [31:0]  data_q;
  logic         run, fall, accept;

  assign run  = (state != IDLE) && (state != RESP);
  assign fall = run && (div_cnt == DIV_LAST) && tck_q;

  // TCK divider; tdo is sampled on the edge that raises TCK
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      tck_q   <= 1'b0;
      tdo_q   <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      tck_q   <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tck_q   <= ~tck_q;
      if (!tck_q) tdo_q <= tdi_sample(tdo_i);
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  function automatic logic tdi_sample(input logic b);
    return b;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= TRST;
      step       <= '0;
      sr         <= '0;
      scan_b     <= 1'b0;
      retry      <= '0;
      rsp_data_o <= '0;
      rsp_op_o   <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state      <= state_next;
      step       <= step_next;
      sr         <= sr_next;
      scan_b     <= scan_b_next;
      retry      <= retry_next;
      rsp_data_o <= rsp_data_next;
      rsp_op_o   <= rsp_op_next;
      if (accept) begin
        op_q   <= req_op_i;
        addr_q <= req_addr_i;
        data_q <= req_data_i;
      end
    end
  end

  // Sequencing advances only on TCK falling edges, so TMS/TDI settle while TCK is low
  always_comb begin
    state_next    = state;
    step_next     = step;
    sr_next       = sr;
    scan_b_next   = scan_b;
    retry_next    = retry;
    rsp_data_next = rsp_data_o;
    rsp_op_next   = rsp_op_o;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          accept = 1'b1;
          if (req_op_i == 2'd3) begin
            rsp_op_next   = 2'd2;
            rsp_data_next = '0;
            state_next    = RESP;
          end else begin
            state_next  = SEL_DR;
            step_next   = '0;
            scan_b_next = 1'b0;
            retry_next  = '0;
          end
        end
      end
      RESP: if (rsp_ready_i) state_next = IDLE;
      default: begin
        if (fall) begin
          step_next = step + 16'd1;
          case (state)
            TRST:      if (step == 16'd3) begin state_next = TAP_RESET; step_next = '0; end
            TAP_RESET: if (step == 16'd5) begin state_next = SEL_IR; step_next = '0; end
            SEL_IR: begin
              if (step == 16'd3) begin
                state_next = SHIFT_IR;
                step_next  = '0;
                sr_next    = {36'd0, DMI_IR};
              end
            end
            SHIFT_IR: begin
              sr_next = {1'b0, sr[40:1]};
              if (step == 16'd6) state_next = IDLE;
            end
            SEL_DR: begin
              if (step == 16'd2) begin
                state_next = SHIFT_DR;
                step_next  = '0;
                sr_next    = scan_b ? {addr_q, 32'h0, 2'd0} : {addr_q, data_q, op_q};
              end
            end
            SHIFT_DR: begin
              sr_next = {tdo_q, sr[40:1]};
              if (step == 16'd40) begin state_next = UPDATE; step_next = '0; end
            end
            UPDATE: if (step == 16'd1) begin state_next = RTI_WAIT; step_next = '0; end
            RTI_WAIT: begin
              if (step == IDLE_LAST) begin
                step_next = '0;
                if (!scan_b) begin
                  scan_b_next = 1'b1;
                  state_next  = SEL_DR;
                end else if (sr[1:0] == 2'd3) begin
                  // busy: MAX_RETRY repeats of the result scan are allowed before giving up
                  if (retry >= RETRY_LIMIT) begin
                    rsp_op_next   = 2'd3;
                    rsp_data_next = sr[33:2];
                    state_next    = RESP;
                  end else begin
                    retry_next = (retry == 5'h1f) ? retry : retry + 5'd1;
                    state_next = SEL_DR;
                  end
                end else begin
                  rsp_op_next   = (sr[1:0] == 2'd0) ? 2'd0 : 2'd2;
                  rsp_data_next = sr[33:2];
                  state_next    = RESP;
                end
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    tms_o = 1'b0;
    case (state)
      TRST:      tms_o = 1'b1;
      TAP_RESET: tms_o = (step < 16'd5);
      SEL_IR:    tms_o = (step < 16'd2);
      SHIFT_IR:  tms_o = (step == 16'd4) || (step == 16'd5);
      SEL_DR:    tms_o = (step == 16'd0);
      SHIFT_DR:  tms_o = (step == 16'd40);
      UPDATE:    tms_o = (step == 16'd0);
      default:   tms_o = 1'b0;
    endcase
  end

  assign tck_o       = tck_q;
  assign tdi_o       = ((state == SHIFT_IR) || (state == SHIFT_DR)) ? sr[0] : 1'b0;
  assign trst_no     = (state != TRST);
  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);

endmodule

// File: doc/jtag_dmi_master.md
JTAG_DMI_MASTER -- requirements
Module: jtag_dmi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: TCK half-period in clk_i cycles, legal range 2..255.
REQ-002 SHALL have parameter IDLE_TCKS, default 8: TCK cycles spent in Run-Test/Idle after each Update-DR.
REQ-003 SHALL have parameter DMI_IR, default 5'h11: the 5-bit IR value shifted to select DMIACCESS.
REQ-004 SHALL have parameter MAX_RETRY, default 16: busy-status retry limit per request.
REQ-005 Port clk_i  in  1  system clock; the only clock.
REQ-006 Port rst_i  in  1  reset, asynchronous, active-high.
REQ-007 Ports req_valid_i in 1, req_ready_o out 1: request handshake.
REQ-008 Ports req_op_i in 2, req_addr_i in 7, req_data_i in 32: DMI op (0 nop, 1 read, 2 write), address and write data.
REQ-009 Ports rsp_valid_o out 1, rsp_ready_i in 1: response handshake.
REQ-010 Ports rsp_data_o out 32, rsp_op_o out 2: captured DMI data and status (0 ok, 2 failed, 3 busy/timeout).
REQ-011 Ports tck_o, tms_o, tdi_o, trst_no out 1; tdo_i in 1: JTAG pins toward the cva6_zybo_z7_20 tck/tms/tdi/trst_n/tdo.

Function
REQ-012 tck_o SHALL toggle every CLK_DIV clk_i cycles while a scan is active and SHALL be held at 0 otherwise.
REQ-013 tms_o and tdi_o SHALL change only on the clk_i edge that drives tck_o low; tdo_i SHALL be sampled on the edge that drives tck_o high.
REQ-014 FSM states SHALL be: TRST, TAP_RESET, IDLE, SEL_IR, SHIFT_IR, SEL_DR, SHIFT_DR, UPDATE, RTI_WAIT, RESP.
REQ-015 TRST SHALL hold trst_no=0 for 4 TCK periods, then go to TAP_RESET.
REQ-016 TAP_RESET SHALL drive TMS=1 for 5 TCKs, then TMS=0 for 1 TCK (Run-Test/Idle), then go to SEL_IR.
REQ-017 SEL_IR SHALL drive TMS sequence 1,1,0,0 to reach Shift-IR; SHIFT_IR SHALL shift DMI_IR LSB first with TMS=1 on the 5th bit, then TMS 1,0 (Update-IR, Run-Test/Idle), then go to IDLE.
REQ-018 IR selection SHALL occur once after reset and never again until the next reset.
REQ-019 req_ready_o SHALL be 1 only in IDLE with rsp_valid_o=0; acceptance occurs when req_valid_i and req_ready_o are both 1, and the request fields SHALL be latched.
REQ-020 Each request SHALL perform scan A with the 41-bit DR {addr,data,op}, then scan B with {addr,32'h0,op=0} to capture the result.
REQ-021 SEL_DR SHALL drive TMS 1,0,0; SHIFT_DR SHALL shift 41 bits LSB first (op[0] first) with TMS=1 on bit 41; UPDATE SHALL drive TMS 1,0; RTI_WAIT SHALL hold TMS=0 for IDLE_TCKS.
REQ-022 Captured scan-B bits SHALL be split as status=bits[1:0] and data=bits[33:2].
REQ-023 If the captured status is 3, scan B SHALL repeat; the retry counter SHALL be 5 bits and saturating.
REQ-024 After MAX_RETRY busy results, the block SHALL enter RESP with rsp_op_o=3.
REQ-025 RESP SHALL assert rsp_valid_o with data and status stable until rsp_ready_i=1, then return to IDLE.
REQ-026 Simultaneous rsp_ready_i and a new req_valid_i SHALL not accept the new request in that same cycle.
REQ-027 A request with op=3 SHALL be accepted and answered immediately with rsp_op_o=2 and no scan.

Reset
REQ-028 While rst_i=1, all outputs SHALL be: tck_o=0, tms_o=1, tdi_o=0, trst_no=0, req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_op_o=0.
REQ-029 On release of rst_i, the FSM SHALL start in TRST.
REQ-030 A reset mid-scan SHALL abort the scan, discard the latched request and produce no response.

Verification
REQ-031 Startup: release rst_i -> trst_no low for 4 TCKs, 5 TMS=1, then IR bits 1,0,0,0,1 on tdi_o; req_ready_o=1 after IR update.
REQ-032 Write op=2, addr=0x10, data=0x00000001 -> DM dmcontrol.dmactive=1; response rsp_op_o=0.
REQ-033 Read op=1, addr=0x11 -> rsp_data_o equals the DM dmstatus value, with rsp_op_o=0.
REQ-034 Busy: TAP model returns status 3 twice then 0 -> exactly 2 extra scan Bs and rsp_op_o=0; with status 3 forever -> 16 retries and rsp_op_o=3.
REQ-035 Back-pressure and timing: rsp_ready_i=0 for 20 cycles -> response held stable and req_ready_o=0; measured TCK period equals 8 clk_i cycles; tms_o/tdi_o never change while tck_o is high.
REQ-036 Reset abort: assert rst_i at DR bit 20 -> outputs at reset values next cycle; no rsp_valid_o; full startup sequence repeats.
